// File: rtl/controller_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, sequencer states and the
// control-strobe bundle, used by the controller, ALU and instruction-register stages.
package controller_pkg;

   typedef enum logic [2:0] {
      OP_HLT = 3'b000,
      OP_SKZ = 3'b001,
      OP_ADD = 3'b010,
      OP_AND = 3'b011,
      OP_XOR = 3'b100,
      OP_LDA = 3'b101,
      OP_STO = 3'b110,
      OP_JMP = 3'b111
   } opcode_e;

   typedef enum logic [3:0] {
      S_INST_ADDR  = 4'd0,
      S_INST_FETCH = 4'd1,
      S_INST_LOAD  = 4'd2,
      S_IDLE       = 4'd3,
      S_OP_ADDR    = 4'd4,
      S_OP_FETCH   = 4'd5,
      S_ALU_OP     = 4'd6,
      S_STORE      = 4'd7,
      S_HALTED     = 4'd8
   } state_e;

   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic inc_pc;
      logic ld_pc;
      logic ld_ac;
      logic data_e;
      logic wr;
      logic halt;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   // Opcodes that read an operand from memory into the accumulator path.
   function automatic logic is_aluop(input opcode_e op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/controller.sv
// Eight-phase instruction sequencer. The opcode is latched once per instruction
// and every strobe is a Moore decode of (state, latched opcode, zero).
module controller
   import controller_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       data_e,
   output logic       wr,
   output logic       halt,
   output logic [3:0] state_out
);

   state_e  state_q, state_d;
   opcode_e op_q, op_d;
   ctrl_t   ctrl;
   logic    aluop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_INST_ADDR;
         op_q    <= OP_HLT;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Capture on the edge leaving INST_LOAD; later opcode changes are ignored.
   assign op_d  = (state_q == S_INST_LOAD) ? opcode_e'(opcode) : op_q;
   assign aluop = is_aluop(op_q);

   always_comb begin
      state_d = S_INST_ADDR;
      case (state_q)
         S_INST_ADDR:  state_d = S_INST_FETCH;
         S_INST_FETCH: state_d = S_INST_LOAD;
         S_INST_LOAD:  state_d = S_IDLE;
         S_IDLE:       state_d = S_OP_ADDR;
         S_OP_ADDR:    state_d = (op_q == OP_HLT) ? S_HALTED : S_OP_FETCH;
         S_OP_FETCH:   state_d = S_ALU_OP;
         S_ALU_OP:     state_d = S_STORE;
         S_STORE:      state_d = S_INST_ADDR;
         S_HALTED:     state_d = S_HALTED;
         default:      state_d = S_INST_ADDR;
      endcase
   end

   always_comb begin
      ctrl = CTRL_NONE;
      case (state_q)
         S_INST_ADDR: begin
            ctrl.sel = 1'b1;
         end
         S_INST_FETCH: begin
            ctrl.sel = 1'b1;
            ctrl.rd  = 1'b1;
         end
         S_INST_LOAD, S_IDLE: begin
            ctrl.sel   = 1'b1;
            ctrl.rd    = 1'b1;
            ctrl.ld_ir = 1'b1;
         end
         S_OP_ADDR: begin
            ctrl.inc_pc = 1'b1;
            ctrl.halt   = (op_q == OP_HLT);
         end
         S_OP_FETCH: begin
            ctrl.rd = aluop;
         end
         S_ALU_OP: begin
            ctrl.rd     = aluop;
            ctrl.ld_ac  = aluop;
            ctrl.inc_pc = (op_q == OP_SKZ) && zero;
            ctrl.ld_pc  = (op_q == OP_JMP);
            ctrl.data_e = (op_q == OP_STO);
         end
         S_STORE: begin
            ctrl.rd     = aluop;
            ctrl.ld_ac  = aluop;
            ctrl.inc_pc = (op_q == OP_JMP);
            ctrl.ld_pc  = (op_q == OP_JMP);
            ctrl.wr     = (op_q == OP_STO);
            ctrl.data_e = (op_q == OP_STO);
         end
         S_HALTED: begin
            ctrl.halt = 1'b1;
         end
         default: ctrl = CTRL_NONE;
      endcase
   end

   assign sel       = ctrl.sel;
   assign rd        = ctrl.rd;
   assign ld_ir     = ctrl.ld_ir;
   assign inc_pc    = ctrl.inc_pc;
   assign ld_pc     = ctrl.ld_pc;
   assign ld_ac     = ctrl.ld_ac;
   assign data_e    = ctrl.data_e;
   assign wr        = ctrl.wr;
   assign halt      = ctrl.halt;
   assign state_out = state_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the instruction sequencer: per-state strobe tables,
// opcode latching, SKZ/JMP/STO/HLT behaviour and asynchronous reset.
module tb_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic       zero = 1'b0;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
   logic [3:0] state_out;

   int vectors = 0;
   int errors  = 0;

   // {sel rd ld_ir inc_pc ld_pc ld_ac data_e wr halt}
   localparam logic [8:0] V_S0    = 9'b100000000;
   localparam logic [8:0] V_S1    = 9'b110000000;
   localparam logic [8:0] V_S2    = 9'b111000000;
   localparam logic [8:0] V_S4    = 9'b000100000;
   localparam logic [8:0] V_RD    = 9'b010000000;
   localparam logic [8:0] V_ALU   = 9'b010001000;
   localparam logic [8:0] V_NONE  = 9'b000000000;
   localparam logic [8:0] V_INC   = 9'b000100000;
   localparam logic [8:0] V_JMP6  = 9'b000010000;
   localparam logic [8:0] V_JMP7  = 9'b000110000;
   localparam logic [8:0] V_STO6  = 9'b000000100;
   localparam logic [8:0] V_STO7  = 9'b000000110;
   localparam logic [8:0] V_HLT4  = 9'b000100001;
   localparam logic [8:0] V_HALTD = 9'b000000001;

   wire [12:0] obs = {state_out, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

   logic [12:0] trace [0:7];
   logic [8:0]  exp_v [0:7];

   controller dut (
      .clock    (clock),
      .reset    (reset),
      .opcode   (opcode),
      .zero     (zero),
      .sel      (sel),
      .rd       (rd),
      .ld_ir    (ld_ir),
      .inc_pc   (inc_pc),
      .ld_pc    (ld_pc),
      .ld_ac    (ld_ac),
      .data_e   (data_e),
      .wr       (wr),
      .halt     (halt),
      .state_out(state_out)
   );

   always #5 clock = ~clock;

   // Leaves the DUT in INST_ADDR at a falling edge with reset released.
   task automatic do_reset();
      @(negedge clock);
      reset  = 1'b0;
      opcode = 3'b000;
      zero   = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Entered at a falling edge in INST_ADDR; records n states into trace.
   task automatic run_instr(input logic [2:0] op, input logic [2:0] op_late,
                            input logic z_alu, input logic z_else, input int n);
      for (int i = 0; i < n; i++) begin
         opcode = (i < 3) ? op : op_late;
         zero   = (i == 6) ? z_alu : z_else;
         #1 trace[i] = obs;
         @(negedge clock);
      end
   endtask

   task automatic set_fetch_prefix();
      exp_v[0] = V_S0;
      exp_v[1] = V_S1;
      exp_v[2] = V_S2;
      exp_v[3] = V_S2;
      exp_v[4] = V_S4;
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if (obs !== {4'd0, V_S0}) begin
         errors++;
         $display("FAIL reset_hold: got %h want %h", obs, {4'd0, V_S0});
      end
      do_reset();
      run_instr(3'b010, 3'b010, 1'b0, 1'b0, 5);
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (obs !== {4'd0, V_S0}) begin
         errors++;
         $display("FAIL reset_async_mid: got %h want %h", obs, {4'd0, V_S0});
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      vectors++;
      if (obs !== {4'd0, V_S0}) begin
         errors++;
         $display("FAIL reset_held_over_edge: got %h want %h", obs, {4'd0, V_S0});
      end
      @(negedge clock);
      #1;
      vectors++;
      if (obs !== {4'd1, V_S1}) begin
         errors++;
         $display("FAIL reset_first_edge: got %h want %h", obs, {4'd1, V_S1});
      end
   endtask

   task automatic test_alu_ops();
      logic [2:0] ops [0:3];
      ops[0] = 3'b010; ops[1] = 3'b011; ops[2] = 3'b100; ops[3] = 3'b101;
      set_fetch_prefix();
      exp_v[5] = V_RD; exp_v[6] = V_ALU; exp_v[7] = V_ALU;
      for (int k = 0; k < 4; k++) begin
         do_reset();
         run_instr(ops[k], ops[k], 1'b0, 1'b0, 8);
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (trace[i] !== {4'(i), exp_v[i]}) begin
               errors++;
               $display("FAIL alu_op%0d st%0d: got %h want %h", ops[k], i, trace[i], {4'(i), exp_v[i]});
            end
         end
         #1;
         vectors++;
         if (obs !== {4'd0, V_S0}) begin
            errors++;
            $display("FAIL alu_wrap op%0d: got %h want %h", ops[k], obs, {4'd0, V_S0});
         end
      end
   endtask

   task automatic test_skz();
      int incs;
      // zero high only in ALU_OP: skip taken
      do_reset();
      run_instr(3'b001, 3'b001, 1'b1, 1'b0, 8);
      incs = 0;
      for (int i = 0; i < 8; i++) incs += int'(trace[i][5]);
      vectors++;
      if (incs !== 2) begin
         errors++;
         $display("FAIL skz_taken_incs: got %0d want 2", incs);
      end
      vectors++;
      if (trace[6] !== {4'd6, V_INC}) begin
         errors++;
         $display("FAIL skz_taken_alu: got %h want %h", trace[6], {4'd6, V_INC});
      end
      // zero high everywhere except ALU_OP: no skip
      do_reset();
      run_instr(3'b001, 3'b001, 1'b0, 1'b1, 8);
      incs = 0;
      for (int i = 0; i < 8; i++) incs += int'(trace[i][5]);
      vectors++;
      if (incs !== 1) begin
         errors++;
         $display("FAIL skz_not_taken_incs: got %0d want 1", incs);
      end
      set_fetch_prefix();
      exp_v[5] = V_NONE; exp_v[6] = V_NONE; exp_v[7] = V_NONE;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (trace[i] !== {4'(i), exp_v[i]}) begin
            errors++;
            $display("FAIL skz_not_taken st%0d: got %h want %h", i, trace[i], {4'(i), exp_v[i]});
         end
      end
   endtask

   task automatic test_jmp_sto();
      do_reset();
      run_instr(3'b111, 3'b111, 1'b0, 1'b0, 8);
      set_fetch_prefix();
      exp_v[5] = V_NONE; exp_v[6] = V_JMP6; exp_v[7] = V_JMP7;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (trace[i] !== {4'(i), exp_v[i]}) begin
            errors++;
            $display("FAIL jmp st%0d: got %h want %h", i, trace[i], {4'(i), exp_v[i]});
         end
      end
      do_reset();
      run_instr(3'b110, 3'b110, 1'b1, 1'b1, 8);
      exp_v[6] = V_STO6; exp_v[7] = V_STO7;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (trace[i] !== {4'(i), exp_v[i]}) begin
            errors++;
            $display("FAIL sto st%0d: got %h want %h", i, trace[i], {4'(i), exp_v[i]});
         end
      end
   endtask

   task automatic test_opcode_latch();
      do_reset();
      run_instr(3'b011, 3'b111, 1'b0, 1'b0, 8);
      set_fetch_prefix();
      exp_v[5] = V_RD; exp_v[6] = V_ALU; exp_v[7] = V_ALU;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (trace[i] !== {4'(i), exp_v[i]}) begin
            errors++;
            $display("FAIL latch_and st%0d: got %h want %h", i, trace[i], {4'(i), exp_v[i]});
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_instr(3'b010, 3'b010, 1'b0, 1'b0, 8);
      run_instr(3'b110, 3'b110, 1'b0, 1'b0, 8);
      set_fetch_prefix();
      exp_v[5] = V_NONE; exp_v[6] = V_STO6; exp_v[7] = V_STO7;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (trace[i] !== {4'(i), exp_v[i]}) begin
            errors++;
            $display("FAIL b2b_sto st%0d: got %h want %h", i, trace[i], {4'(i), exp_v[i]});
         end
      end
   endtask

   task automatic test_hlt();
      int bad;
      do_reset();
      run_instr(3'b000, 3'b000, 1'b0, 1'b0, 5);
      set_fetch_prefix();
      exp_v[4] = V_HLT4;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (trace[i] !== {4'(i), exp_v[i]}) begin
            errors++;
            $display("FAIL hlt st%0d: got %h want %h", i, trace[i], {4'(i), exp_v[i]});
         end
      end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         zero   = c[0];
         opcode = c[2:0];
         #1;
         if (obs !== {4'd8, V_HALTD}) begin
            bad++;
            $display("FAIL halted_c%0d: got %h want %h", c, obs, {4'd8, V_HALTD});
         end
         @(negedge clock);
      end
      vectors++;
      if (bad !== 0) errors++;
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (obs !== {4'd0, V_S0}) begin
         errors++;
         $display("FAIL hlt_async_reset: got %h want %h", obs, {4'd0, V_S0});
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset_in_alu();
      do_reset();
      run_instr(3'b110, 3'b110, 1'b0, 1'b0, 6);
      #1;
      vectors++;
      if (obs !== {4'd6, V_STO6}) begin
         errors++;
         $display("FAIL alu_reset_pre: got %h want %h", obs, {4'd6, V_STO6});
      end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (obs !== {4'd0, V_S0}) begin
         errors++;
         $display("FAIL alu_reset_async: got %h want %h", obs, {4'd0, V_S0});
      end
      @(posedge clock);
      #1;
      vectors++;
      if ({state_out, wr, ld_pc} !== 6'b0000_00) begin
         errors++;
         $display("FAIL alu_reset_no_pulse: got %b want %b", {state_out, wr, ld_pc}, 6'b0);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_skz();
      test_jmp_sto();
      test_opcode_latch();
      test_back_to_back();
      test_hlt();
      test_reset_in_alu();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameters: none.
REQ-002 clock  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately.
REQ-004 opcode  input  3  instruction opcode from the instruction-register stage (Opcode_out).
REQ-005 zero  input  1  accumulator-equals-zero flag.
REQ-006 sel  output  1  address mux select, 1 = PC, 0 = operand address.
REQ-007 rd  output  1  memory read strobe.
REQ-008 ld_ir  output  1  instruction-register load enable.
REQ-009 inc_pc  output  1  program-counter increment.
REQ-010 ld_pc  output  1  program-counter load (jump).
REQ-011 ld_ac  output  1  accumulator load.
REQ-012 data_e  output  1  data-bus drive enable for store.
REQ-013 wr  output  1  memory write strobe.
REQ-014 halt  output  1  CPU halted indication.
REQ-015 state_out  output  4  current state encoding, for debug.

Function
REQ-016 Opcode map: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111; ALUOP = ADD|AND|XOR|LDA.
REQ-017 States and encodings: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, HALTED=8.
REQ-018 Sequence: INST_ADDR->INST_FETCH->INST_LOAD->IDLE->OP_ADDR->OP_FETCH->ALU_OP->STORE->INST_ADDR, one state per clock, 8 clocks per instruction.
REQ-019 On the rising edge leaving INST_LOAD, the opcode input is captured into an internal opcode register (op_q); all opcode-dependent outputs use op_q, never the live input.
REQ-020 In OP_ADDR with op_q=HLT, the next state is HALTED instead of OP_FETCH.
REQ-021 HALTED: self-loop until reset; halt=1, all other outputs 0.
REQ-022 Outputs are Moore-style combinational decodes of (state, op_q, zero); no output depends on the live opcode input.
REQ-023 INST_ADDR: sel=1. INST_FETCH: sel=1, rd=1. INST_LOAD and IDLE: sel=1, rd=1, ld_ir=1.
REQ-024 OP_ADDR: inc_pc=1; halt=1 when op_q=HLT.
REQ-025 OP_FETCH: rd=ALUOP.
REQ-026 ALU_OP: rd=ALUOP, ld_ac=ALUOP, inc_pc=(op_q==SKZ && zero), ld_pc=(op_q==JMP), data_e=(op_q==STO).
REQ-027 STORE: rd=ALUOP, ld_ac=ALUOP, inc_pc=(op_q==JMP), ld_pc=(op_q==JMP), wr=(op_q==STO), data_e=(op_q==STO).
REQ-028 Outputs not listed for a state are 0; ld_pc and wr are never 1 in the same state as ld_ir.
REQ-029 zero is sampled only in ALU_OP; changes in other states have no effect.
REQ-030 Unused state encodings 9-15 transition to INST_ADDR on the next clock with all outputs 0.

Reset
REQ-031 While reset=0: state=INST_ADDR, op_q=000; outputs sel=1, state_out=0, all others 0.
REQ-032 Reset assertion mid-instruction (any state, including HALTED) aborts immediately, without waiting for a clock edge; the first rising edge after deassertion moves to INST_FETCH.

Structure
REQ-033 A shared package holds opcode constants and the state encoding, reused by the ALU and instruction-register stages.
REQ-034 Single module, no sub-modules; state register and op_q are the only sequential elements.

Verification
REQ-035 Reset release, opcode=010 (ADD) held: state_out steps 0..7, then 0; ld_ir=1 in states 2-3, rd=1 in states 5-7, ld_ac=1 in states 6-7.
REQ-036 SKZ with zero=1 in ALU_OP: inc_pc=1 in OP_ADDR and in ALU_OP, 2 increments total; repeated with zero=0 gives 1 increment.
REQ-037 JMP: ld_pc=1 in ALU_OP and STORE, inc_pc=1 in OP_ADDR and STORE; STO: data_e=1 in states 6-7, wr=1 only in state 7.
REQ-038 HLT: halt=1 in OP_ADDR, next state_out=8, stays 8 for 20 clocks with halt=1, then reset=0 gives state_out=0 asynchronously.
REQ-039 Opcode input changed to 111 in IDLE after 011 was captured: behaviour stays AND; ld_pc stays 0.
REQ-040 reset pulsed low during ALU_OP, asynchronous to clock: outputs go to reset values immediately and no wr/ld_pc pulse occurs.
